// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the mouse front end: transmit FSM states,
// host command bytes and frame construction.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    RELEASE
  } ps2_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;

  // Index of the stop bit; bits 0..8 are data LSB-first followed by parity.
  localparam logic [3:0] STOP_BIT_IDX = 4'd9;

  // Host frame as shifted out LSB first: {stop, odd parity, data}.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for a raw PS/2 line, followed by a glitch filter that
// accepts a level change only after FILTER_CYCLES consecutive equal samples.
module ps2_line_sync #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic sync_out,
  output logic filt_out,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: synchroniser and filter reset to 1, the idle level of an open-collector line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
        fall_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign sync_out = sync_q;
  assign filt_out = filt_q;
  assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send
// and shifts one command byte out on device-generated clock falls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_ok_q, ack_ok_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             data_meta_q, data_sync_q;

  logic clk_sync_unused;
  logic clk_filt;
  logic clk_fall;
  logic timeout;

  ps2_line_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .sync_out(clk_sync_unused),
    .filt_out(clk_filt),
    .fall    (clk_fall)
  );

  assign timeout = (to_cnt_q == TO_LAST);

  // NOTE: sequential state is assigned with <= only; the async reset drops both oe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ack_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ack_ok_q    <= ack_ok_d;
      done_q      <= done_d;
      error_q     <= error_d;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  // Timeout outranks a clock fall in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tx_valid) state_d = INHIBIT;
      INHIBIT: if (data_oe_q) state_d = SEND;
      SEND: begin
        if (timeout) state_d = IDLE;
        else if (clk_fall && bit_cnt_q == STOP_BIT_IDX) state_d = ACK;
      end
      ACK: begin
        if (timeout) state_d = IDLE;
        else if (clk_fall) state_d = RELEASE;
      end
      RELEASE: begin
        if (timeout) state_d = IDLE;
        else if (clk_filt && data_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = '0;
    to_cnt_d  = '0;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d   = make_frame(tx_data);
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
        end
      end
      // Clock held low for the inhibit time, then start bit, then clock released.
      INHIBIT: begin
        if (data_oe_q) clk_oe_d = 1'b0;
        else if (inh_cnt_q == INH_LAST) data_oe_d = 1'b1;
        else inh_cnt_d = inh_cnt_q + INH_W'(1);
      end
      SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
        end else if (clk_fall) begin
          if (bit_cnt_q == STOP_BIT_IDX) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b0, frame_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
        end else if (clk_fall) begin
          ack_ok_d = ~data_sync_q;
        end
      end
      RELEASE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
        end else if (clk_filt && data_sync_q) begin
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND bus and a behavioural
// PS/2 device that clocks frames, optionally acks, glitches or stalls.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int FILT = 8;
  localparam int HALF = 40;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  logic dev_clk_low, dev_data_low, glitch_low;
  logic ps2_clk_line, ps2_data_line;

  int n_checks, n_fail;
  int done_cnt, err_cnt, accept_cnt;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
  end

  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Counts negedges while the host holds the clock low; ends on the first released sample.
  task automatic wait_clk_release(output int lat, output logic start_bit);
    lat = 0;
    while (ps2_clk_oe && lat < INH + 50) begin
      lat++;
      @(negedge clk);
    end
    start_bit = ps2_data_oe;
  endtask

  task automatic start_frame(input logic [7:0] data, output logic accepted,
                             output int lat, output logic start_bit);
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    accepted = busy & ~tx_ready & ps2_clk_oe;
    wait_clk_release(lat, start_bit);
  endtask

  // Device side of one frame; abort_at leaves the clock held low at that bit.
  task automatic device_frame(input logic do_ack, input int abort_at, input int glitch_at,
                              output logic [9:0] bits, output logic ok);
    ok   = 1'b0;
    bits = '0;
    for (int i = 0; i < 400; i++) begin
      if (ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) break;
      @(negedge clk);
    end
    if (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1)) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        repeat (HALF / 2) @(negedge clk);
        ok = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      bits[i]     = ps2_data_line;
      dev_clk_low = 1'b0;
      if (i == glitch_at) begin
        repeat (HALF / 2) @(negedge clk);
        glitch_low = 1'b1;
        repeat (2) @(negedge clk);
        glitch_low = 1'b0;
        repeat (HALF - HALF / 2 - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (do_ack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_pulse(input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(tx_done || tx_error) && cyc <= bound);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error} !== 6'b100000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error});
    end
  endtask

  // Full frame with hand-computed parity; checks line bits and the completion pulse.
  task automatic test_frame(input string name, input logic [7:0] data, input logic [9:0] exp_bits,
                            input logic do_ack, input int glitch_at);
    logic [9:0] bits;
    logic ok, accepted, start_bit;
    int lat, cyc, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(data, accepted, lat, start_bit);
    n_checks++;
    if (accepted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: busy/!ready/clk_oe got %b expected 1", name, accepted);
    end
    n_checks++;
    if (lat !== INH + 1) begin
      n_fail++;
      $display("FAIL %s inhibit_latency: got %0d expected %0d", name, lat, INH + 1);
    end
    n_checks++;
    if (start_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_bit: data_oe got %b expected 1", name, start_bit);
    end
    device_frame(do_ack, -1, glitch_at, bits, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s request_seen: got %b expected 1", name, ok);
    end
    n_checks++;
    if (bits !== exp_bits) begin
      n_fail++;
      $display("FAIL %s line_bits: got %b expected %b", name, bits, exp_bits);
    end
    wait_pulse(3 + FILT, cyc);
    n_checks++;
    if (cyc > 3 + FILT || tx_done !== do_ack || tx_error !== ~do_ack) begin
      n_fail++;
      $display("FAIL %s pulse: after %0d cycles done=%b error=%b expected done=%b within %0d",
               name, cyc, tx_done, tx_error, do_ack, 3 + FILT);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== int'(do_ack) || err_cnt - e0 !== int'(!do_ack)) begin
      n_fail++;
      $display("FAIL %s pulse_count: done=%0d error=%0d expected done=%0d error=%0d",
               name, done_cnt - d0, err_cnt - e0, int'(do_ack), int'(!do_ack));
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s released: clk_oe/data_oe/ready got %b expected 001", name, {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
  endtask

  task automatic test_timeout();
    logic accepted, start_bit;
    int lat, cyc, d0;
    d0 = done_cnt;
    start_frame(CMD_SET_RATE, accepted, lat, start_bit);
    wait_pulse(TO + 100, cyc);
    n_checks++;
    if (cyc !== TO || tx_error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: error=%b after %0d cycles expected 1 after %0d", tx_error, cyc, TO);
    end
    @(negedge clk);
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy} !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_release: clk_oe/data_oe/ready/busy got %b expected 0010",
               {ps2_clk_oe, ps2_data_oe, tx_ready, busy});
    end
    n_checks++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL timeout_no_done: got %0d done pulses expected 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    logic ok, accepted, start_bit;
    int lat, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'hEF, accepted, lat, start_bit);
    device_frame(1'b1, 4, -1, bits, ok);
    n_checks++;
    if ({ok, ps2_data_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_bit4_driven: ok/data_oe got %b expected 11", {ok, ps2_data_oe});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_async_release: clk_oe/data_oe/busy/ready got %b expected 0001",
               {ps2_clk_oe, ps2_data_oe, busy, tx_ready});
    end
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    reset       = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0 || err_cnt !== e0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: done=%0d error=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    test_frame("after_abort_ff", CMD_RESET, 10'b1_1_1111_1111, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    logic ok, start_bit;
    int lat, cyc, d0, a0;
    d0 = done_cnt;
    a0 = accept_cnt;
    @(negedge clk);
    tx_data  = CMD_SET_RATE;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hAA;
    wait_clk_release(lat, start_bit);
    device_frame(1'b1, -1, -1, bits, ok);
    n_checks++;
    if (bits !== 10'b1_1_1111_0011) begin
      n_fail++;
      $display("FAIL held_valid_first_byte: got %b expected %b", bits, 10'b1_1_1111_0011);
    end
    wait_pulse(3 + FILT, cyc);
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL held_valid_reaccept: ready got %b expected 0", tx_ready);
    end
    tx_valid = 1'b0;
    wait_clk_release(lat, start_bit);
    device_frame(1'b1, -1, -1, bits, ok);
    n_checks++;
    if (bits !== 10'b1_1_1010_1010) begin
      n_fail++;
      $display("FAIL held_valid_second_byte: got %b expected %b", bits, 10'b1_1_1010_1010);
    end
    wait_pulse(3 + FILT, cyc);
    repeat (20) @(negedge clk);
    n_checks++;
    if (accept_cnt - a0 !== 2 || done_cnt - d0 !== 2) begin
      n_fail++;
      $display("FAIL held_valid_counts: accepts=%0d done=%0d expected 2 2", accept_cnt - a0, done_cnt - d0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    done_cnt     = 0;
    err_cnt      = 0;
    accept_cnt   = 0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    glitch_low   = 1'b0;
    reset        = 1'b1;

    test_reset();
    test_frame("send_f4", CMD_ENABLE, 10'b1_0_1111_0100, 1'b1, -1);
    test_frame("nack_00", 8'h00, 10'b1_1_0000_0000, 1'b0, -1);
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_frame("glitch_3c", 8'h3C, 10'b1_1_0011_1100, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
